// File: rtl/rr_bus_arbiter_if.sv
// Request/grant bundle between the masters and rr_bus_arbiter.
// master = requester side, slave = arbiter side.
interface rr_bus_arbiter_if #(
   parameter int N_REQ = 4
) ();
   localparam int ID_W = $clog2(N_REQ);

   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] grant;
   logic [ID_W-1:0]  grant_id;
   logic             busy;
   logic [ID_W-1:0]  prio_ptr;
   logic             forced_rel;

   modport master (
      output req,
      input  grant, grant_id, busy, prio_ptr, forced_rel
   );

   modport slave (
      input  req,
      output grant, grant_id, busy, prio_ptr, forced_rel
   );
endinterface

// File: rtl/rr_bus_arbiter.sv
// N-requester round-robin arbiter with registered one-hot grant and a one-cycle turnaround.
// Optional hold-time revocation is compiled in with RR_ARB_TIMEOUT_EN.
module rr_bus_arbiter #(
   parameter int N_REQ    = 4,
   parameter int MAX_HOLD = 8
) (
   input logic           clk,
   input logic           rst,
   rr_bus_arbiter_if.slave bus
);
   localparam int ID_W = $clog2(N_REQ);
   localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      GRANT   = 2'b01,
      RELEASE = 2'b10
   } state_t;

   if (N_REQ < 2 || N_REQ > 16 || MAX_HOLD < 2) begin : g_bad_param
      $error("rr_bus_arbiter: illegal N_REQ/MAX_HOLD");
   end

   state_t           state_r;
   logic [N_REQ-1:0] grant_r;
   logic [ID_W-1:0]  grant_id_r;
   logic [ID_W-1:0]  prio_ptr_r;
   logic             busy_r;

   logic             win_found_s;
   logic [ID_W-1:0]  win_id_s;
   logic             drop_s;
   logic             timeout_s;

   function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] id);
      logic [ID_W-1:0] nxt;
      if (id == ID_W'(N_REQ - 1)) begin
         nxt = {ID_W{1'b0}};
      end else begin
         nxt = id + ID_W'(1);
      end
      return nxt;
   endfunction

   // rotating-priority search; walking from lowest to highest priority lets the last hit win
   always_comb begin
      int              k;
      logic [ID_W-1:0] idx;
      k           = 0;
      idx         = {ID_W{1'b0}};
      win_found_s = 1'b0;
      win_id_s    = {ID_W{1'b0}};
      for (int i = N_REQ - 1; i >= 0; i--) begin
         k   = (int'(prio_ptr_r) + i) % N_REQ;
         idx = ID_W'(k);
         if (bus.req[idx]) begin
            win_found_s = 1'b1;
            win_id_s    = idx;
         end else begin
            win_found_s = win_found_s;
            win_id_s    = win_id_s;
         end
      end
   end

   assign drop_s = ~bus.req[grant_id_r];

`ifdef RR_ARB_TIMEOUT_EN
   localparam int HOLD_W = $clog2(MAX_HOLD + 1);

   logic [HOLD_W-1:0] hold_r;
   logic [HOLD_W-1:0] hold_inc_s;
   logic              forced_rel_r;

   // saturating hold count including the current cycle; revoke only when someone else waits
   always_comb begin
      if (hold_r < HOLD_W'(MAX_HOLD)) begin
         hold_inc_s = hold_r + HOLD_W'(1);
      end else begin
         hold_inc_s = hold_r;
      end
      timeout_s = (hold_inc_s == HOLD_W'(MAX_HOLD)) &&
                  ((bus.req & ~grant_r) != {N_REQ{1'b0}});
   end

   // hold counter and forced-release pulse
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold_r       <= {HOLD_W{1'b0}};
         forced_rel_r <= 1'b0;
      end else begin
         forced_rel_r <= (state_r == GRANT) && !drop_s && timeout_s;
         if (state_r == GRANT) begin
            hold_r <= hold_inc_s;
         end else begin
            hold_r <= {HOLD_W{1'b0}};
         end
      end
   end

   assign bus.forced_rel = forced_rel_r;
`else
   assign timeout_s      = 1'b0;
   assign bus.forced_rel = 1'b0;
`endif

   // arbitration FSM with registered grant outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r    <= IDLE;
         grant_r    <= {N_REQ{1'b0}};
         grant_id_r <= {ID_W{1'b0}};
         busy_r     <= 1'b0;
         prio_ptr_r <= {ID_W{1'b0}};
      end else begin
         case (state_r)
            IDLE, RELEASE: begin
               if (win_found_s) begin
                  state_r    <= GRANT;
                  grant_r    <= ONE_HOT0 << win_id_s;
                  grant_id_r <= win_id_s;
                  busy_r     <= 1'b1;
               end else begin
                  state_r    <= IDLE;
                  grant_r    <= {N_REQ{1'b0}};
                  grant_id_r <= {ID_W{1'b0}};
                  busy_r     <= 1'b0;
               end
            end
            GRANT: begin
               if (drop_s || timeout_s) begin
                  state_r    <= RELEASE;
                  grant_r    <= {N_REQ{1'b0}};
                  grant_id_r <= {ID_W{1'b0}};
                  busy_r     <= 1'b0;
                  prio_ptr_r <= next_idx(grant_id_r);
               end else begin
                  state_r    <= GRANT;
               end
            end
            default: begin
               state_r    <= IDLE;
               grant_r    <= {N_REQ{1'b0}};
               grant_id_r <= {ID_W{1'b0}};
               busy_r     <= 1'b0;
            end
         endcase
      end
   end

   assign bus.grant    = grant_r;
   assign bus.grant_id = grant_id_r;
   assign bus.busy     = busy_r;
   assign bus.prio_ptr = prio_ptr_r;
endmodule
